// File: rtl/runadd_pkg.sv
// Shared state encoding and constants for the running-sum scheduler.
package runadd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_SETTLE = 3'd3,
        ST_RESULT = 3'd4
    } state_t;

    localparam int DW_DEF = 8;
    localparam int SW_DEF = 32;
    localparam int CNT_W  = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/runadd_sched_if.sv
// Producer, accumulator and result signals of the running-sum scheduler.
interface runadd_sched_if import runadd_pkg::*; #(
    parameter int NREQ = 4,
    parameter int DW   = DW_DEF,
    parameter int SW   = SW_DEF,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_last;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               acc_clr;
    logic               acc_en;
    logic [DW-1:0]      acc_data;
    logic [SW-1:0]      acc_sum;
    logic               res_valid;
    logic               res_ready;
    logic [SW-1:0]      res_sum;
    logic [IDW-1:0]     res_id;
    logic [CNT_W-1:0]   res_count;
    logic               busy;

    // The scheduler is the slave; producers, accumulator and consumer form the master side.
    modport slave (
        input  req_valid, req_last, req_data, acc_sum, res_ready,
        output req_ready, acc_clr, acc_en, acc_data, res_valid, res_sum, res_id, res_count, busy
    );

    modport master (
        output req_valid, req_last, req_data, acc_sum, res_ready,
        input  req_ready, acc_clr, acc_en, acc_data, res_valid, res_sum, res_id, res_count, busy
    );
endinterface

// File: rtl/runadd_sched_rr_arbiter.sv
// Combinational rotating-priority arbiter: first set request at or above the pointer, with wrap.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_gnt_id
);
    logic [IDW:0]   w_pos;
    logic [IDW-1:0] w_idx;
    logic           w_found;

    always_comb begin
        o_gnt    = '0;
        o_gnt_id = '0;
        w_found  = 1'b0;
        w_pos    = '0;
        w_idx    = '0;
        for (int off = 0; off < NREQ; off++) begin
            w_pos = {1'b0, i_ptr} + (IDW+1)'(off);
            if (w_pos >= (IDW+1)'(NREQ)) begin
                w_pos = w_pos - (IDW+1)'(NREQ);
            end
            w_idx = w_pos[IDW-1:0];
            if (!w_found && i_req[w_idx]) begin
                w_found      = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_gnt_id     = w_idx;
            end
        end
    end
endmodule

// File: rtl/runadd_sched.sv
// Round-robin scheduler sharing one external running-sum accumulator between NREQ producers.
module runadd_sched import runadd_pkg::*; #(
    parameter int NREQ = 4,
    parameter int DW   = DW_DEF,
    parameter int SW   = SW_DEF,
    parameter int IDW  = 2
) (
    input  logic          clk,
    input  logic          reset,
    runadd_sched_if.slave bus
);
    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_gnt_id;
    logic [CNT_W-1:0] r_count;
    logic [SW-1:0]    r_res_sum;
    logic [IDW-1:0]   r_res_id;
    logic [CNT_W-1:0] r_res_count;

    logic [NREQ-1:0]  w_arb_gnt;
    logic [IDW-1:0]   w_arb_id;
    logic             w_arb_any;
    logic [NREQ-1:0]  w_req_ready;
    logic             w_acc_clr;
    logic             w_acc_en;
    logic [DW-1:0]    w_acc_data;
    logic             w_beat;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] id);
        return (id == IDW'(NREQ-1)) ? '0 : id + IDW'(1);
    endfunction

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .i_req    (bus.req_valid),
        .i_ptr    (r_ptr),
        .o_gnt    (w_arb_gnt),
        .o_gnt_id (w_arb_id)
    );

    assign w_arb_any = |w_arb_gnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = '0;
        w_acc_clr   = 1'b0;
        w_acc_en    = 1'b0;
        w_acc_data  = '0;
        w_beat      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_any) w_state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                w_acc_clr   = 1'b1;
                w_state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                // A last flag without valid is not a beat and cannot end the burst.
                w_req_ready[r_gnt_id] = 1'b1;
                w_beat   = bus.req_valid[r_gnt_id];
                w_acc_en = w_beat;
                if (w_beat) begin
                    w_acc_data = bus.req_data[r_gnt_id*DW +: DW];
                    if (bus.req_last[r_gnt_id]) w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                w_state_nxt = ST_RESULT;
            end
            ST_RESULT: begin
                if (bus.res_ready) w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr       <= '0;
            r_gnt_id    <= '0;
            r_count     <= '0;
            r_res_sum   <= '0;
            r_res_id    <= '0;
            r_res_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_any) begin
                        r_gnt_id <= w_arb_id;
                        r_count  <= '0;
                    end
                end
                ST_STREAM: begin
                    if (w_beat) r_count <= sat_inc(r_count);
                end
                // The accumulator has absorbed the last beat by now.
                ST_SETTLE: begin
                    r_res_sum   <= bus.acc_sum;
                    r_res_id    <= r_gnt_id;
                    r_res_count <= r_count;
                end
                ST_RESULT: begin
                    if (bus.res_ready) r_ptr <= next_ptr(r_gnt_id);
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.acc_clr   = w_acc_clr;
    assign bus.acc_en    = w_acc_en;
    assign bus.acc_data  = w_acc_data;
    assign bus.res_valid = (r_state == ST_RESULT);
    assign bus.res_sum   = r_res_sum;
    assign bus.res_id    = r_res_id;
    assign bus.res_count = r_res_count;
    assign bus.busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_runadd_sched.sv
// Directed bench for runadd_sched with an attached accumulator model.
module tb_runadd_sched;
    import runadd_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [31:0] acc_model = '0;
    int          beats [4];
    logic [3:0]  accepted;
    logic        got;
    int          order [5] = '{0, 1, 2, 3, 0};

    runadd_sched_if #(.NREQ(4), .DW(8), .SW(32), .IDW(2)) bus ();

    runadd_sched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // External accumulator: registered, clear has priority, not touched by reset.
    always_ff @(posedge clk) begin
        if (bus.acc_clr)     acc_model <= '0;
        else if (bus.acc_en) acc_model <= acc_model + 32'(bus.acc_data);
    end
    assign bus.acc_sum = acc_model;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int k, input logic [7:0] v);
        bus.req_data[k*8 +: 8] = v;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'h0);
        chk({tag, "_clr"},   32'(bus.acc_clr),   32'h0);
        chk({tag, "_en"},    32'(bus.acc_en),    32'h0);
        chk({tag, "_data"},  32'(bus.acc_data),  32'h0);
        chk({tag, "_rvld"},  32'(bus.res_valid), 32'h0);
        chk({tag, "_rsum"},  bus.res_sum,        32'h0);
        chk({tag, "_rid"},   32'(bus.res_id),    32'h0);
        chk({tag, "_rcnt"},  32'(bus.res_count), 32'h0);
        chk({tag, "_busy"},  32'(bus.busy),      32'h0);
    endtask

    task automatic chk_result(input string tag, input logic [31:0] sum, input int id, input int cnt);
        chk({tag, "_rvld"}, 32'(bus.res_valid), 32'h1);
        chk({tag, "_rsum"}, bus.res_sum,        sum);
        chk({tag, "_rid"},  32'(bus.res_id),    32'(id));
        chk({tag, "_rcnt"}, 32'(bus.res_count), 32'(cnt));
    endtask

    task automatic handshake(input string tag);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk({tag, "_drop"}, 32'(bus.res_valid), 32'h0);
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.res_ready = 1'b0;

        // Reset held with every requester asking for a single-sample burst of 5
        bus.req_valid = 4'hF;
        bus.req_last  = 4'hF;
        for (int k = 0; k < 4; k++) set_data(k, 8'h05);
        repeat (3) tick();
        chk_all_zero("rst");
        bus.res_ready = 1'b1;
        reset = 1'b1;
        tick();
        chk("rst_clr_pulse", 32'(bus.acc_clr), 32'h1);
        chk("rst_busy", 32'(bus.busy), 32'h1);
        chk("rst_clr_noready", 32'(bus.req_ready), 32'h0);
        tick();
        chk("rst_clr_once", 32'(bus.acc_clr), 32'h0);
        chk("rst_first_grant", 32'(bus.req_ready), 32'h1);
        chk("rst_acc_en", 32'(bus.acc_en), 32'h1);
        chk("rst_acc_data", 32'(bus.acc_data), 32'h5);
        tick();
        bus.req_valid = '0;
        bus.req_last  = '0;
        chk("rst_settle_novld", 32'(bus.res_valid), 32'h0);
        tick();
        chk_result("rst_res", 32'd5, 0, 1);
        handshake("rst_hs");
        chk("rst_idle_busy", 32'(bus.busy), 32'h0);

        // Single burst of 1..10 from requester 2
        bus.req_valid = 4'b0100;
        set_data(2, 8'd1);
        tick();
        tick();
        for (int i = 1; i <= 10; i++) begin
            set_data(2, 8'(i));
            bus.req_last[2] = (i == 10);
            #1;
            chk("single_ready", 32'(bus.req_ready), 32'h4);
            chk("single_data", 32'(bus.acc_data), 32'(i));
            tick();
        end
        bus.req_valid = '0;
        bus.req_last  = '0;
        chk("single_c12_novld", 32'(bus.res_valid), 32'h0);
        tick();
        chk_result("single", 32'd55, 2, 10);

        // Backpressure: result held while requester 0 waits
        bus.req_valid = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk_result("bp", 32'd55, 2, 10);
            chk("bp_noready", 32'(bus.req_ready), 32'h0);
            chk("bp_noclr", 32'(bus.acc_clr), 32'h0);
        end
        bus.req_valid = '0;
        handshake("single_hs");

        // Return the pointer to 0 before the contention run
        reset = 1'b0;
        #1;
        chk("rst2_busy", 32'(bus.busy), 32'h0);
        tick();
        reset = 1'b1;

        // Contention: all four continuously send 3-sample bursts of k+1
        for (int k = 0; k < 4; k++) begin
            beats[k] = 0;
            set_data(k, 8'(k + 1));
        end
        bus.req_valid = 4'hF;
        for (int n = 0; n < 5; n++) begin
            got = 1'b0;
            for (int c = 0; c < 20; c++) begin
                for (int k = 0; k < 4; k++) bus.req_last[k] = (beats[k] % 3 == 2);
                #1;
                if (bus.res_valid === 1'b1) begin
                    got = 1'b1;
                    break;
                end
                if (bus.req_ready != 4'h0) chk("cont_ready", 32'(bus.req_ready), 32'h1 << order[n]);
                accepted = bus.req_ready & bus.req_valid;
                tick();
                for (int k = 0; k < 4; k++) if (accepted[k]) beats[k]++;
            end
            chk("cont_timeout", 32'(got), 32'h1);
            chk_result("cont", 32'(3 * (order[n] + 1)), order[n], 3);
            handshake("cont_hs");
        end
        bus.req_valid = '0;
        bus.req_last  = '0;
        tick();
        chk("cont_idle", 32'(bus.busy), 32'h0);

        // Requester 1: five 8'hFF beats with 2-cycle gaps; last without valid in the gaps
        bus.req_valid = 4'b0010;
        set_data(1, 8'hFF);
        tick();
        tick();
        for (int b = 0; b < 5; b++) begin
            bus.req_valid[1] = 1'b1;
            bus.req_last[1]  = (b == 4);
            tick();
            if (b < 4) begin
                bus.req_valid[1] = 1'b0;
                bus.req_last[1]  = 1'b1;
                #1;
                chk("gap_en", 32'(bus.acc_en), 32'h0);
                chk("gap_data", 32'(bus.acc_data), 32'h0);
                chk("gap_ready", 32'(bus.req_ready), 32'h2);
                tick();
                tick();
            end
        end
        bus.req_valid = '0;
        bus.req_last  = '0;
        tick();
        chk_result("stall", 32'd1275, 1, 5);
        handshake("stall_hs");

        // Single-sample burst from requester 3
        bus.req_valid = 4'b1000;
        bus.req_last  = 4'b1000;
        set_data(3, 8'h80);
        tick();
        tick();
        chk("one_en", 32'(bus.acc_en), 32'h1);
        chk("one_data", 32'(bus.acc_data), 32'h80);
        chk("one_ready", 32'(bus.req_ready), 32'h8);
        tick();
        bus.req_valid = '0;
        bus.req_last  = '0;
        tick();
        chk_result("one", 32'd128, 3, 1);
        handshake("one_hs");

        // Reset after three beats of a burst from requester 0
        bus.req_valid = 4'b0001;
        set_data(0, 8'h01);
        tick();
        tick();
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk_all_zero("midrst");
        bus.req_valid = '0;
        tick();
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("midrst_nores", 32'(bus.res_valid), 32'h0);
        end
        bus.req_valid = 4'b0001;
        tick();
        tick();
        tick();
        bus.req_last[0] = 1'b1;
        tick();
        bus.req_valid = '0;
        bus.req_last  = '0;
        tick();
        chk_result("after_rst", 32'd2, 0, 2);
        handshake("after_rst_hs");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
